dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single word-wide data memory between requester 0 (core load/store unit) and requester 1 (debug/loader port). Each accepted request is latched, presented to the memory for exactly one cycle, and answered with a registered one-cycle acknowledge carrying read data or an error flag. Misaligned and out-of-range accesses are rejected without touching memory. The block sits between the two requesters and the data memory's `i_stb`/`i_wr_en`/`i_addr`/`i_write_data`/`o_read_data` port.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes; the last legal word address is `MEM_BYTES-4`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `i_r0_req` / `i_r1_req`  in  1  request valid; must be held, with stable fields, until the matching ack.
- `i_r0_wr_en` / `i_r1_wr_en`  in  1  1 = write, 0 = read.
- `i_r0_addr` / `i_r1_addr`  in  32  byte address.
- `i_r0_wdata` / `i_r1_wdata`  in  32  write data.
- `o_r0_ack` / `o_r1_ack`  out  1  one-cycle completion pulse.
- `o_r0_rdata` / `o_r1_rdata`  out  32  read data; valid while ack is high, else 0.
- `o_r0_err` / `o_r1_err`  out  1  valid with ack: access rejected.
- `o_mem_stb`  out  1  drives memory `i_stb`.
- `o_mem_wr_en`  out  1  drives memory `i_wr_en`.
- `o_mem_addr`  out  32  drives memory `i_addr`.
- `o_mem_wdata`  out  32  drives memory `i_write_data`.
- `i_mem_rd_ack`  in  1  memory read acknowledge; read data is only captured when high.
- `i_mem_rdata`  in  32  memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: grant id `gnt`, latched request (wr_en, addr, wdata), error bit, rdata buffer, round-robin pointer `last`.
- IDLE: if any request, arbitrate, latch the winner's fields, compute err = `addr[1:0]!=0` or `addr > MEM_BYTES-4`, go to ACCESS.
- ACCESS: if err = 0, drive `o_mem_stb=1`, `o_mem_wr_en`=latched wr_en, addr/wdata from latch. If err = 1, drive all memory outputs to 0. For a read with `i_mem_rd_ack=1`, capture `i_mem_rdata`; otherwise capture 0. Go to RESP.
- RESP: pulse `o_rN_ack` for the granted N. Drive `o_rN_rdata` from the buffer (0 for writes and errors) and `o_rN_err` from the error bit. In the same cycle, arbitrate among requests with the served requester masked. If there is a winner, latch it and go to ACCESS; otherwise go to IDLE.
- Arbitration: per Configuration. `last` updates on every grant.
- Outputs for the non-granted requester, and all memory outputs outside ACCESS, are 0.
- Memory write occurs on the clock edge that ends ACCESS.

## Timing
- Reset (`rst_n`=0 at an edge): state becomes IDLE and `last` = 1, so requester 0 wins the first tie. Every output reads 0 combinationally while `rst_n`=0. Any in-flight access is dropped with no ack, and the memory write is suppressed.
- Latency: request seen in IDLE at cycle 0 -> ACCESS at cycle 1 -> ack at cycle 2.
- Back-to-back throughput: one access every 2 cycles (ACCESS, RESP alternate).
- The requester must deassert `req`, or present a new request, in the cycle after ack. The one-cycle mask in RESP prevents re-serving a held request.
- A request dropped before ack is a protocol violation; behaviour is unspecified, but the FSM always completes to RESP.
- Simultaneous requests in IDLE: one grant only; the loser waits and is granted from RESP.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: on contention, grant the requester not equal to `last`. Under continuous load, grants alternate 0,1,0,1.
- Not defined: fixed priority, requester 0 always wins. Requester 1 is served only when `i_r0_req`=0 at an arbitration point, or when requester 0 is masked in RESP.

## Test plan
- Reset: hold `rst_n`=0 with both requests high for 3 cycles -> all outputs 0, no memory write. On release, requester 0 is acked 2 cycles after the first IDLE edge.
- Write then read: r0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> acks at cycles 2 and 4, `o_r0_rdata`=0xDEADBEEF, err 0.
- Misaligned and out-of-range: r1 reads 0x13, then writes to 0x3FD with `MEM_BYTES`=1024 -> ack with `o_r1_err`=1 and rdata 0. `o_mem_stb` stays 0 and memory contents are unchanged.
- Contention with `DMEM_ARB_ROUND_ROBIN_EN`: both requests held high, each re-issued after its ack -> ack order r0,r1,r0,r1 on cycles 2,4,6,8.
- Contention without the macro: same stimulus -> r1 is granted only in RESP slots following an r0 ack. Verify no double ack to the requester still holding `req` in its ack cycle.
- Reset mid-operation: assert `rst_n`=0 during ACCESS of an r1 write to 0x20 -> no ack, location 0x20 unchanged, FSM in IDLE afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one word-wide data memory between requester 0 (core LSU) and
// requester 1 (debug/loader). Each accepted request is latched, shown to
// the memory for exactly one cycle (ACCESS), then answered with a one-cycle
// ack (RESP). Misaligned or out-of-range accesses never strobe the memory
// and are acked with err=1 and rdata=0.
//
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : on contention grant the requester that did not win last.
//   undefined : fixed priority, requester 0 wins whenever it is eligible.
//
// Handshake: a requester raises i_rN_req with stable wr_en/addr/wdata and
// holds it until o_rN_ack pulses for one cycle; err/rdata are valid only
// with that ack. In the ack cycle it may keep req (masked for that one
// arbitration) or present a new request; it must not hold an already
// served request past the ack cycle.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_rN_req/wr_en/addr/wdata  request from requester N (N = 0, 1)
//   o_rN_ack/rdata/err      one-cycle completion to requester N
//   o_mem_stb/wr_en/addr/wdata  memory command, active only in ACCESS
//   i_mem_rd_ack, i_mem_rdata   memory read response (combinational)
//   o_dbg_state             FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//   o_dbg_last              round-robin pointer (last granted requester)
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_r0_req,
  input  logic        i_r0_wr_en,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_wdata,
  input  logic        i_r1_req,
  input  logic        i_r1_wr_en,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_wdata,
  output logic        o_r0_ack,
  output logic [31:0] o_r0_rdata,
  output logic        o_r0_err,
  output logic        o_r1_ack,
  output logic [31:0] o_r1_rdata,
  output logic        o_r1_err,
  output logic        o_mem_stb,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rd_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_last
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        last_q, last_d;

  logic        r0_elig, r1_elig, any_elig, pick;
  logic        sel_wr_en;
  logic [31:0] sel_addr, sel_wdata;

  // Arbitration and next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    last_d  = last_q;

    // The requester being acked in RESP may still hold req; mask it so the
    // same request is not served twice.
    r0_elig = i_r0_req;
    r1_elig = i_r1_req;
    if (state_q == ST_RESP) begin
      if (gnt_q == 1'b0) r0_elig = 1'b0;
      else               r1_elig = 1'b0;
    end
    any_elig = r0_elig | r1_elig;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    pick = (r0_elig && r1_elig) ? ~last_q : ~r0_elig;
`else
    pick = ~r0_elig;
`endif

    sel_wr_en = pick ? i_r1_wr_en : i_r0_wr_en;
    sel_addr  = pick ? i_r1_addr  : i_r0_addr;
    sel_wdata = pick ? i_r1_wdata : i_r0_wdata;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_elig) begin
          gnt_d   = pick;
          last_d  = pick;
          wr_en_d = sel_wr_en;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Writes and rejected accesses answer with rdata 0.
        rdata_d = (!wr_en_q && !err_q && i_mem_rd_ack) ? i_mem_rdata : 32'd0;
        state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  // Outputs: all forced to 0 while reset is asserted, which also keeps an
  // in-flight write from reaching the memory.
  always_comb begin
    o_r0_ack    = 1'b0;
    o_r0_rdata  = 32'd0;
    o_r0_err    = 1'b0;
    o_r1_ack    = 1'b0;
    o_r1_rdata  = 32'd0;
    o_r1_err    = 1'b0;
    o_mem_stb   = 1'b0;
    o_mem_wr_en = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    o_dbg_state = 2'd0;
    o_dbg_last  = 1'b0;
    if (rst_n) begin
      o_dbg_state = state_q;
      o_dbg_last  = last_q;
      case (state_q)
        ST_ACCESS: begin
          if (!err_q) begin
            o_mem_stb   = 1'b1;
            o_mem_wr_en = wr_en_q;
            o_mem_addr  = addr_q;
            o_mem_wdata = wdata_q;
          end
        end
        ST_RESP: begin
          if (gnt_q == 1'b0) begin
            o_r0_ack   = 1'b1;
            o_r0_rdata = rdata_q;
            o_r0_err   = err_q;
          end else begin
            o_r1_ack   = 1'b1;
            o_r1_rdata = rdata_q;
            o_r1_err   = err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a 256-word memory model attached.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        r0_req, r0_wr_en, r1_req, r1_wr_en;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_stb, mem_wr_en, mem_rd_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic        dbg_last;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_r0_req(r0_req), .i_r0_wr_en(r0_wr_en), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
    .i_r1_req(r1_req), .i_r1_wr_en(r1_wr_en), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
    .o_r0_ack(r0_ack), .o_r0_rdata(r0_rdata), .o_r0_err(r0_err),
    .o_r1_ack(r1_ack), .o_r1_rdata(r1_rdata), .o_r1_err(r1_err),
    .o_mem_stb(mem_stb), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rd_ack(mem_rd_ack), .i_mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state), .o_dbg_last(dbg_last)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  assign mem_rd_ack = mem_stb && !mem_wr_en;
  assign mem_rdata  = mem[mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (mem_stb && mem_wr_en) mem[mem_addr[9:2]] = mem_wdata;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam logic FIRST_E = 1'b1;
`else
  localparam logic FIRST_E = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];  // {port, rdata} in expected ack order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int port, input logic req, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      r0_req = req; r0_wr_en = wr; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = req; r1_wr_en = wr; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  // Single isolated access: request from IDLE, ACCESS next cycle, ack after.
  task automatic do_access(input int port, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata);
    set_req(port, 1'b1, wr, addr, wdata);
    tick();
    check($sformatf("acc_state@%0h", addr), dbg_state, 32'd1);
    check($sformatf("acc_stb@%0h", addr), mem_stb, !exp_err);
    if (!exp_err) begin
      check($sformatf("acc_addr@%0h", addr), mem_addr, addr);
      check($sformatf("acc_wr@%0h", addr), mem_wr_en, wr);
    end
    tick();
    check($sformatf("ack@%0h", addr), (port == 0) ? r0_ack : r1_ack, 32'd1);
    check($sformatf("other_ack@%0h", addr), (port == 0) ? r1_ack : r0_ack, 32'd0);
    check($sformatf("err@%0h", addr), (port == 0) ? r0_err : r1_err, exp_err);
    check($sformatf("rdata@%0h", addr), (port == 0) ? r0_rdata : r1_rdata, exp_rdata);
    set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check($sformatf("idle@%0h", addr), dbg_state, 32'd0);
    check($sformatf("no_reack@%0h", addr), r0_ack | r1_ack, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [32:0] e;
    int nack, n0, n1;

    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held with both requests high.
    set_req(0, 1'b1, 1'b0, 32'h40, 32'd0);
    set_req(1, 1'b1, 1'b1, 32'h44, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ack0", r0_ack, 32'd0);
      check("rst_ack1", r1_ack, 32'd0);
      check("rst_stb", mem_stb, 32'd0);
      check("rst_wr_en", mem_wr_en, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_state", dbg_state, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_stb", mem_stb, 32'd1);
    check("rel_addr", mem_addr, 32'h40);
    check("rel_last", dbg_last, 32'd0);
    tick();
    check("rel_ack0", r0_ack, 32'd1);
    check("rel_rdata0", r0_rdata, 32'hA500_0010);
    check("rel_ack1_low", r1_ack, 32'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("rel_r1_wr_en", mem_wr_en, 32'd1);
    check("rel_r1_addr", mem_addr, 32'h44);
    check("rel_mem_untouched", mem[17], 32'hA500_0011);
    tick();
    check("rel_ack1", r1_ack, 32'd1);
    check("rel_err1", r1_err, 32'd0);
    check("rel_rdata1", r1_rdata, 32'd0);
    check("rel_mem_written", mem[17], 32'h1111_2222);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("rel_idle", dbg_state, 32'd0);
    check("rel_no_reack", r1_ack, 32'd0);

    // Isolated accesses: write/read, misaligned, out-of-range, boundary.
    do_access(0, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'd0);
    do_access(0, 1'b0, 32'h10,  32'd0,         1'b0, 32'hDEAD_BEEF);
    do_access(1, 1'b0, 32'h13,  32'd0,         1'b1, 32'd0);
    do_access(1, 1'b1, 32'h3FD, 32'hCAFE_0000, 1'b1, 32'd0);
    do_access(1, 1'b0, 32'h400, 32'd0,         1'b1, 32'd0);
    do_access(0, 1'b0, 32'hFFFF_FFFC, 32'd0,   1'b1, 32'd0);
    do_access(1, 1'b0, 32'h3FC, 32'd0,         1'b0, 32'hA500_00FF);
    do_access(1, 1'b1, 32'h3FC, 32'h1234_5678, 1'b0, 32'd0);
    do_access(0, 1'b0, 32'h3FC, 32'd0,         1'b0, 32'h1234_5678);

    // Contention from a fresh reset: both held, each re-issued once.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_q.push_back({1'b1, 32'h1234_5678});
    exp_q.push_back({1'b0, 32'h1234_5678});
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    set_req(0, 1'b1, 1'b0, 32'h10,  32'd0);
    set_req(1, 1'b1, 1'b0, 32'h3FC, 32'd0);
    nack = 0; n0 = 0; n1 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("cont_dual_ack_c%0d", k), r0_ack & r1_ack, 32'd0);
      if ((r0_ack || r1_ack) && exp_q.size() > 0) begin
        nack++;
        e = exp_q.pop_front();
        check($sformatf("cont_port_%0d", nack), r1_ack, e[32]);
        check($sformatf("cont_rdata_%0d", nack), r1_ack ? r1_rdata : r0_rdata, e[31:0]);
        check($sformatf("cont_cycle_%0d", nack), k, 2 * nack);
        if (r0_ack) begin
          n0++;
          if (n0 == 1) set_req(0, 1'b1, 1'b0, 32'h3FC, 32'd0);
          else         set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        if (r1_ack) begin
          n1++;
          if (n1 == 1) set_req(1, 1'b1, 1'b0, 32'h10, 32'd0);
          else         set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end else if (r0_ack || r1_ack) begin
        nack++;
      end
    end
    check("cont_ack_count", nack, 32'd4);
    check("cont_idle", dbg_state, 32'd0);

    // Tie in IDLE after requester 0 was the last grant.
    do_access(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);
    set_req(0, 1'b1, 1'b0, 32'h10,  32'd0);
    set_req(1, 1'b1, 1'b0, 32'h3FC, 32'd0);
    tick();
    check("tie_addr", mem_addr, FIRST_E ? 32'h3FC : 32'h10);
    tick();
    check("tie_ack0", r0_ack, !FIRST_E);
    check("tie_ack1", r1_ack, FIRST_E);
    check("tie_rdata", FIRST_E ? r1_rdata : r0_rdata, FIRST_E ? 32'h1234_5678 : 32'hDEAD_BEEF);
    set_req(FIRST_E ? 1 : 0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("tie_loser_addr", mem_addr, FIRST_E ? 32'h10 : 32'h3FC);
    tick();
    check("tie_loser_ack0", r0_ack, FIRST_E);
    check("tie_loser_ack1", r1_ack, !FIRST_E);
    check("tie_loser_rdata", FIRST_E ? r0_rdata : r1_rdata, FIRST_E ? 32'hDEAD_BEEF : 32'h1234_5678);
    tick();  // loser still holds req through its ack cycle
    check("tie_no_double_ack", r0_ack | r1_ack, 32'd0);
    check("tie_idle", dbg_state, 32'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("tie_still_idle", dbg_state, 32'd0);

    // Reset during ACCESS of an r1 write.
    set_req(1, 1'b1, 1'b1, 32'h20, 32'hBAD0_BAD0);
    tick();
    check("mid_stb", mem_stb, 32'd1);
    check("mid_addr", mem_addr, 32'h20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb_comb", mem_stb, 32'd0);
    tick();
    check("mid_no_ack", r1_ack, 32'd0);
    check("mid_mem_kept", mem[8], 32'hA500_0008);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_idle", dbg_state, 32'd0);
    check("mid_no_late_ack", r1_ack, 32'd0);
    do_access(0, 1'b0, 32'h20, 32'd0, 1'b0, 32'hA500_0008);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
